// File: rtl/mod_phase_mapper.sv
// Streaming BPSK/QPSK bit-to-phase mapper with cyclic offset.
// One-symbol output register behind a valid/ready handshake.
module mod_phase_mapper #(
  parameter int CYC_DIV = 24,
  parameter int CW      = $clog2(CYC_DIV)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_bit,
  input  logic          i_valid,
  output logic          o_ready,
  input  logic          i_last,
  input  logic          i_mode,
  input  logic [CW-1:0] i_cyc_offset,
  output logic [CW-1:0] o_cyc_part,
  output logic          o_valid,
  input  logic          i_ready,
  output logic          o_last,
  output logic          o_pad
);

  typedef enum logic {
    EMPTY = 1'b0,
    HALF  = 1'b1
  } state_t;

  localparam logic [CW:0] DW = (CW+1)'(CYC_DIV);
  localparam logic [CW:0] M1 = (CW+1)'(CYC_DIV / 8);
  localparam logic [CW:0] M3 = (CW+1)'(3 * CYC_DIV / 8);
  localparam logic [CW:0] M5 = (CW+1)'(5 * CYC_DIV / 8);
  localparam logic [CW:0] M7 = (CW+1)'(7 * CYC_DIV / 8);

  state_t        state_q;
  logic          b0_q;
  logic [CW-1:0] off_q;

  logic          valid_q;
  logic [CW-1:0] cyc_q;
  logic          last_q;
  logic          pad_q;

  logic          in_xfer;
  logic          complete;
  logic          sym_q;
  logic          sym_b0;
  logic          sym_b1;
  logic          sym_pad;
  logic [CW-1:0] sym_off;
  logic [CW:0]   map;
  logic [CW:0]   sum;
  logic [CW-1:0] cyc_d;

  assign o_ready = !valid_q || i_ready;
  assign in_xfer = i_valid && o_ready;

  always_comb begin
    sym_q    = i_mode;
    sym_b0   = i_bit;
    sym_b1   = 1'b0;
    sym_off  = i_cyc_offset;
    sym_pad  = 1'b0;
    complete = 1'b0;
    if (state_q == HALF) begin
      sym_q    = 1'b1;
      sym_b0   = b0_q;
      sym_b1   = i_bit;
      sym_off  = off_q;
      complete = in_xfer;
    end else begin
      complete = in_xfer && (!i_mode || i_last);
      sym_pad  = i_mode && i_last;
    end
  end

  // Gray-ordered QPSK constellation; BPSK uses the 00/11 points
  always_comb begin
    map = M1;
    unique case (1'b1)
      !sym_q:                        map = sym_b0 ? M5 : M1;
      sym_q && !sym_b0 && !sym_b1:   map = M1;
      sym_q && !sym_b0 &&  sym_b1:   map = M3;
      sym_q &&  sym_b0 &&  sym_b1:   map = M5;
      sym_q &&  sym_b0 && !sym_b1:   map = M7;
      default:                       map = M1;
    endcase
  end

  assign sum   = map + {1'b0, sym_off};
  assign cyc_d = (sum >= DW) ? CW'(sum - DW) : CW'(sum);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= EMPTY;
      b0_q    <= 1'b0;
      off_q   <= '0;
    end else if (in_xfer) begin
      if (state_q == EMPTY) begin
        if (i_mode && !i_last) begin
          state_q <= HALF;
          b0_q    <= i_bit;
          off_q   <= i_cyc_offset;
        end
      end else begin
        state_q <= EMPTY;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_q <= 1'b0;
      cyc_q   <= '0;
      last_q  <= 1'b0;
      pad_q   <= 1'b0;
    end else if (complete) begin
      valid_q <= 1'b1;
      cyc_q   <= cyc_d;
      last_q  <= i_last;
      pad_q   <= sym_pad;
    end else if (valid_q && i_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign o_valid    = valid_q;
  assign o_cyc_part = cyc_q;
  assign o_last     = last_q;
  assign o_pad      = pad_q;

endmodule

// File: doc/mod_phase_mapper.md
Name: mod_phase_mapper

Overview:
- Streaming successor to the combinational QPSK cycle-part mapper.
- Accepts serial data bits under a valid/ready handshake and groups them into BPSK (1 bit) or QPSK (2 bits) symbols, selectable per symbol.
- Maps each symbol to a phase index in 1/CYC_DIV cycle units, adds a per-symbol cyclic offset modulo CYC_DIV, and emits the result through a registered valid/ready output.
- Sits between the PUCCH bit source and the sequence phase-rotation stage.

Parameters:
- CYC_DIV, 24: divider of the full cycle. Must be a multiple of 8 and at least 8.
- CW, $clog2(CYC_DIV): width of phase-index ports. Must satisfy 2**CW >= CYC_DIV.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous reset, active-high.
- i_bit  in  1  data bit; b0 first, then b1 for QPSK.
- i_valid  in  1  i_bit valid.
- o_ready  out  1  block accepts i_bit this cycle.
- i_last  in  1  qualifies i_bit as last bit of the stream.
- i_mode  in  1  0 = BPSK, 1 = QPSK. Sampled with b0.
- i_cyc_offset  in  CW  cyclic offset, 0..CYC_DIV-1. Sampled with b0.
- o_cyc_part  out  CW  phase index, 0..CYC_DIV-1.
- o_valid  out  1  o_cyc_part valid.
- i_ready  in  1  downstream accepts output.
- o_last  out  1  output symbol is the last of the stream.
- o_pad  out  1  QPSK symbol was completed with padded b1 = 0.

Behaviour:
- **Reset:** synchronous, active-high on i_clk; dominates all other inputs.
  - Clears o_valid, o_last, o_pad and o_cyc_part to 0.
  - Sets the input FSM to EMPTY and discards any held b0.
  - Reset mid-symbol or mid-output drops that data.
- **Handshakes:**
  - Input transfer occurs when i_valid && o_ready.
  - Output transfer occurs when o_valid && i_ready.
  - o_ready = !o_valid || i_ready (combinational from i_ready and the o_valid register).
  - While o_valid=1 and i_ready=0: o_cyc_part, o_last and o_pad hold stable.
- **Mapping (D = CYC_DIV):**
  - QPSK b0b1: 00 -> D/8, 01 -> 3D/8, 11 -> 5D/8, 10 -> 7D/8.
  - BPSK b0: 0 -> D/8, 1 -> 5D/8.
- **Offset arithmetic:**
  - sum = map + offset, computed at CW+1 bits.
  - o_cyc_part = sum >= D ? sum - D : sum.
  - An offset >= D is out of contract; the output is then unspecified, but the block must not hang.
- **FSM states:**
  - EMPTY, on input transfer:
    - If i_mode=0 (BPSK): symbol complete; remain in EMPTY.
    - If i_mode=1 and i_last=0: store b0, mode and offset; go to HALF.
    - If i_mode=1 and i_last=1: symbol complete with b1=0 and pad=1; remain in EMPTY.
  - HALF, on input transfer:
    - The bit is b1; symbol complete using the latched mode and offset; go to EMPTY.
    - i_mode and i_cyc_offset are ignored in HALF.
    - i_last is taken from this beat.
- **Output load:**
  - On symbol complete, the output register loads o_cyc_part, o_last = i_last of the completing beat, and o_pad.
  - o_valid is set the next cycle.
  - Latency: 1 cycle from the completing input beat to o_valid.
- **Throughput and simultaneous events:**
  - Output transfer and a new completing input beat in the same cycle: the register reloads and o_valid stays 1.
  - Back-to-back sustained rate: 1 bit per cycle; 1 symbol/cycle BPSK, 1 symbol per 2 cycles QPSK.
  - Output transfer with no new symbol: o_valid clears next cycle.
- **Idle conditions:**
  - i_valid=0 in HALF: hold b0 indefinitely; no timeout.
  - No combinational path from i_valid to o_valid.

Test Plan:
- **Reset:** D=24, assert i_rst for 2 cycles while i_valid=1 -> o_valid=0, o_cyc_part=0, o_ready=1 after release, and no output generated.
- **QPSK map:** i_mode=1, offset=0, i_ready=1, bits 00,01,11,10 -> o_cyc_part 3, 9, 15, 21 on consecutive odd cycles, each 1 cycle after b1.
- **BPSK with wrap:** i_mode=0, offset=20, bits 0,1 -> 23, then (15+20-24)=11, at 1 symbol/cycle.
- **Offset and mode latch:** QPSK b0=1 with offset=22, then change to offset=5 and i_mode=0 before b1=1 -> output (15+22-24)=13; the changes are ignored.
- **Padding:** QPSK b0=1 with i_last=1 in EMPTY -> o_cyc_part=21 (10 mapping), o_pad=1, o_last=1.
- **Backpressure:** hold i_ready=0 after the first symbol -> o_ready drops, o_cyc_part stable for 5 cycles, no bits lost; then i_ready=1 with a simultaneous completing beat -> o_valid stays 1 and the outputs appear in order.
